// File: rtl/icache_dm.sv
// Direct-mapped, blocking instruction cache with flop storage and a single-line burst refill.
// Returns up to FETCH_WIDTH consecutive instructions per request; lanes past the line end are masked off.
module icache_dm #(
  parameter int FETCH_WIDTH = 4,
  parameter int LINE_WORDS  = 8,
  parameter int NUM_SETS    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_pc,
  output logic                    resp_valid,
  output logic [32*FETCH_WIDTH-1:0] resp_inst,
  output logic [FETCH_WIDTH-1:0]  resp_mask,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [31:0]             mem_resp_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT  = OFF_W'(LINE_WORDS - 1);
  localparam logic [OFF_W:0]   LINE_LIMIT = (OFF_W+1)'(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    DONE
  } state_t;

  state_t state, state_n;

  // Word address of the accepted request; byte-offset bits are never used.
  logic [29:0] fetch_pc;
  logic        unused_pc_bits;
  assign unused_pc_bits = ^req_pc[1:0];

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  assign offset = fetch_pc[OFF_W-1:0];
  assign index  = fetch_pc[OFF_W +: IDX_W];
  assign tag    = fetch_pc[29 -: TAG_W];

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [31:0]         data_mem [NUM_SETS][LINE_WORDS];

  logic [OFF_W-1:0] cnt;
  logic             flush_seen;

  logic hit;
  logic accept;
  logic fill_beat;
  logic fill_commit;

  assign hit = valid[index] && (tag_mem[index] == tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    accept        = 1'b0;
    fill_beat     = 1'b0;
    fill_commit   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n && !flush;
        accept    = req_valid && req_ready;
        if (accept) state_n = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid = !flush;
          req_ready  = !flush;
          accept     = req_valid && req_ready;
          state_n    = accept ? LOOKUP : IDLE;
        end else begin
          // A flush here means the miss is dropped before it ever reaches the bus.
          state_n = flush ? IDLE : MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_n = REFILL;
      end
      REFILL: begin
        if (mem_resp_valid) begin
          fill_beat = 1'b1;
          if (cnt == LAST_BEAT) begin
            fill_commit = !(flush_seen || flush);
            state_n     = fill_commit ? DONE : IDLE;
          end
        end
      end
      DONE: begin
        resp_valid = !flush;
        req_ready  = !flush;
        accept     = req_valid && req_ready;
        state_n    = accept ? LOOKUP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_req_addr = mem_req_valid ? {fetch_pc[29:OFF_W], {(2+OFF_W){1'b0}}} : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= '0;
      cnt        <= '0;
      flush_seen <= 1'b0;
      valid      <= '0;
    end else begin
      if (accept) fetch_pc <= req_pc[31:2];

      if (state == MISS_REQ) begin
        cnt <= '0;
      end else if (fill_beat) begin
        cnt <= cnt + 1'b1;
      end

      // Remembers a flush that arrives while the refill is outstanding.
      if (state == LOOKUP) begin
        flush_seen <= 1'b0;
      end else if ((state == MISS_REQ || state == REFILL) && flush) begin
        flush_seen <= 1'b1;
      end

      if (flush) begin
        valid <= '0;
      end else if (fill_commit) begin
        valid[index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) data_mem[index][cnt] <= mem_resp_data;
    if (fill_commit) tag_mem[index] <= tag;
  end

  logic [OFF_W:0] lane_sum;

  always_comb begin
    resp_inst = '0;
    resp_mask = '0;
    lane_sum  = '0;
    if (resp_valid) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        lane_sum = {1'b0, offset} + (OFF_W+1)'(i);
        if (lane_sum < LINE_LIMIT) begin
          resp_mask[i]          = 1'b1;
          resp_inst[32*i +: 32] = data_mem[index][lane_sum[OFF_W-1:0]];
        end
      end
    end
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised, direct-mapped, blocking instruction cache. Successor to the fixed ROM fetch source.
- Sits between the fetch-stage PC generator and the instruction memory bus.
- Returns up to FETCH_WIDTH consecutive 32-bit instructions per request, with a per-lane valid mask.
- On a miss, refills one full line over a burst read interface.

Parameters:
FETCH_WIDTH, 4, instructions returned per request (power of two, <= LINE_WORDS)
LINE_WORDS, 8, 32-bit words per cache line (power of two, >= 2)
NUM_SETS, 64, number of lines (power of two)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  invalidate all lines; kill in-flight response
req_valid  in  1  fetch request valid
req_ready  out  1  cache can accept request this cycle
req_pc  in  32  fetch PC (bits [1:0] ignored)
resp_valid  out  1  response valid (single cycle, no backpressure)
resp_inst  out  32*FETCH_WIDTH  lane i = instruction at word offset+i
resp_mask  out  FETCH_WIDTH  lane i valid iff offset+i < LINE_WORDS
mem_req_valid  out  1  line refill request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  line-aligned byte address
mem_resp_valid  in  1  refill data beat valid (always accepted)
mem_resp_data  in  32  refill word, beats in order word 0..LINE_WORDS-1

Behaviour:
- Address split: offset = pc[2+:log2(LINE_WORDS)]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Storage: per set one valid bit, one tag, and LINE_WORDS data words, all in flops.
- Reset (async, rst_n=0):
  - all valid bits cleared; state IDLE; beat counter 0.
  - outputs: req_ready=0 during reset, then 1 in IDLE; resp_valid=0; resp_inst=0; resp_mask=0; mem_req_valid=0; mem_req_addr=0.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, DONE.
- IDLE:
  - req_ready = !flush.
  - Accept (req_valid && req_ready): latch pc, go to LOOKUP.
- LOOKUP (cycle after accept):
  - Hit = valid[index] && tag match.
  - On hit: resp_valid=1 with data this cycle (latency 1). req_ready = !flush. A new accept stays in LOOKUP (1 fetch/cycle throughput); otherwise go to IDLE.
  - On miss: resp_valid=0, req_ready=0; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = {pc[31:2+log2(LINE_WORDS)], 0}.
  - Hold both until mem_req_ready, then go to REFILL.
  - Once asserted, valid is never dropped before the handshake, even on flush.
- REFILL:
  - Each mem_resp_valid writes data[index][cnt]; cnt increments.
  - On beat LINE_WORDS-1: write tag, set valid (unless a flush was seen since the miss), go to DONE.
  - mem_resp_valid outside REFILL is ignored.
- DONE:
  - resp_valid=1 with the refilled line, unless flush is pending or active.
  - req_ready = !flush; accept goes to LOOKUP, else IDLE.
- Lane output: resp_inst lane i = data[index][offset+i] when resp_mask[i]=1, else 0.
  - Fetch groups never cross a line.
  - resp_inst and resp_mask are 0 whenever resp_valid=0.
- Flush:
  - Clears all valid bits next edge.
  - In LOOKUP/DONE: resp_valid forced 0 that cycle.
  - In MISS_REQ/REFILL: the refill completes on the bus, the line is not validated, no response is issued, and the FSM returns to IDLE.
  - Flush with simultaneous req_valid: request not accepted.
- Reset mid-refill: FSM returns to IDLE immediately, mem_req_valid drops. Any remaining beats after reset are ignored.

Test Plan:
- Cold miss (defaults), req_pc=0x0 → mem_req_addr=0x0. Feed beats 0x34010001, 0x34020001, 0x34030000, 0x24040000, 0x24050001, 0x24060008, 0, 0. One cycle after the last beat: resp_valid=1, resp_inst lanes = 0x34010001, 0x34020001, 0x34030000, 0x24040000; resp_mask=4'b1111.
- Hit after fill: req_pc=0x8 → one cycle later resp_valid=1, lanes = 0x34030000, 0x24040000, 0x24050001, 0x24060008; no mem_req_valid.
- Line-end mask: req_pc=0x18 → resp_mask=4'b0011, lane0=word6, lane1=word7, lanes2/3=0.
- Back-to-back hits at 0x0, 0x4, 0x8 on consecutive cycles → three consecutive resp_valid cycles; req_ready held 1.
- Conflict miss at 0x800 (same index, different tag) → refill issued; subsequent 0x0 misses again.
- Flush during REFILL beat 3 → no response; line stays invalid; re-request of 0x0 misses.
- Reset asserted mid-REFILL → all outputs return to reset values immediately; after release, 0x0 misses.
